// File: rtl/branch_resolve.sv
// branch_resolve: two-stage pipelined branch/SLT resolution with valid/ready, flush and saturating stats.
module mag_cmp #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             gt,
    output logic             lt,
    output logic             eq
);
    logic diff;
    // Differing sign bits decide a signed compare outright.
    assign diff = SIGNED && (a[WIDTH-1] != b[WIDTH-1]);
    assign eq   = a == b;
    assign lt   = diff ? a[WIDTH-1] : a < b;
    assign gt   = diff ? b[WIDTH-1] : a > b;
endmodule

module branch_resolve #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [15:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_is_branch,
    output logic             out_taken,
    output logic [WIDTH-1:0] out_target,
    output logic [WIDTH-1:0] out_slt,
    output logic [31:0]      branch_count,
    output logic [31:0]      taken_count
);
    logic             s1_valid, s1_adv, acc, hs;
    logic [2:0]       s1_op;
    logic [WIDTH-1:0] s1_a, s1_b, s1_pc, seq, br;
    logic [15:0]      s1_imm;
    logic             gt_u, lt_u, eq_u, gt_s, lt_s, eq_s;
    logic             ge_u, ge_s, cond, is_br, taken;
    logic [7:0]       conds;

    mag_cmp #(.WIDTH(WIDTH), .SIGNED(1'b0)) u_cmp (.a(s1_a), .b(s1_b), .gt(gt_u), .lt(lt_u), .eq(eq_u));
    mag_cmp #(.WIDTH(WIDTH), .SIGNED(1'b1)) s_cmp (.a(s1_a), .b(s1_b), .gt(gt_s), .lt(lt_s), .eq(eq_s));

    assign ge_u   = gt_u || eq_u;
    assign ge_s   = gt_s || eq_s;
    // Indexed by op: SLTU, SLT, BGEU, BLTU, BGE, BLT, BNE, BEQ.
    assign conds  = {lt_u, lt_s, ge_u, lt_u, ge_s, lt_s, !eq_u, eq_u};
    assign cond   = conds[s1_op];
    assign is_br  = !(s1_op[2] && s1_op[1]);
    assign taken  = is_br && cond;
    assign seq    = s1_pc + 32'd4;
    assign br     = seq + {{(WIDTH-18){s1_imm[15]}}, s1_imm, 2'b00};

    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || s1_adv;
    assign acc      = in_valid && in_ready;
    assign hs       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid      <= 1'b0;
            s1_op         <= '0;
            s1_a          <= '0;
            s1_b          <= '0;
            s1_pc         <= '0;
            s1_imm        <= '0;
            out_valid     <= 1'b0;
            out_is_branch <= 1'b0;
            out_taken     <= 1'b0;
            out_target    <= '0;
            out_slt       <= '0;
            branch_count  <= '0;
            taken_count   <= '0;
        end else begin
            if (hs && out_is_branch && !(&branch_count))
                branch_count <= branch_count + 32'd1;
            if (hs && out_taken && !(&taken_count))
                taken_count <= taken_count + 32'd1;
            s1_valid  <= !flush && (acc || (s1_valid && !s1_adv));
            out_valid <= !flush && (s1_adv || (out_valid && !out_ready));
            if (acc && !flush) begin
                s1_op  <= in_op;
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_pc  <= in_pc;
                s1_imm <= in_imm;
            end
            if (s1_adv && !flush) begin
                out_is_branch <= is_br;
                out_taken     <= taken;
                out_target    <= taken ? br : seq;
                out_slt       <= {{(WIDTH-1){1'b0}}, cond && !is_br};
            end
        end
    end
endmodule
